// File: rtl/guess_pkg.sv
// Shared definitions for the guess-number game: round timer state encoding
// and default timebase constants.
package guess_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam int DEF_DIV_LIMIT     = 2500;
    localparam int DEF_TICKS_PER_SEC = 20000;

endpackage

// File: rtl/tick_prescaler.sv
// Enabled modulo counter 0..LIMIT. wrap_o flags the enabled step out of LIMIT;
// tick_o is the same event registered, so it is a clean 1-cycle pulse.
module tick_prescaler #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o,
    output logic wrap_o
);

    localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    logic [CW-1:0] cnt_q;
    logic          tick_q;

    // A clear in the same cycle as the terminal step swallows the tick.
    assign wrap_o = en_i && !clr_i && (cnt_q == CW'(LIMIT));
    assign tick_o = tick_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap_o;
            if (clr_i)
                cnt_q <= '0;
            else if (en_i)
                cnt_q <= (cnt_q == CW'(LIMIT)) ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// Round timebase: free-running scan prescaler plus a RUN-gated seconds stage
// driving the per-round countdown FSM (start/pause/clear, expiry).
module round_timer_ctrl
    import guess_pkg::*;
#(
    parameter int DIV_LIMIT     = DEF_DIV_LIMIT,
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int TW            = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pause,
    input  logic          clr,
    input  logic [TW-1:0] round_len,
    output logic          scan_tick,
    output logic          sec_tick,
    output logic [TW-1:0] time_left,
    output logic          running,
    output logic          expired,
    output logic          expire_pulse
);

    state_e        state_q;
    logic [TW-1:0] time_left_q;
    logic          running_q, expired_q, expire_pulse_q;
    logic          sec_en, sec_wrap, scan_wrap_unused;

    tick_prescaler #(.LIMIT(DIV_LIMIT)) u_scan (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .clr_i  (1'b0),
        .tick_o (scan_tick),
        .wrap_o (scan_wrap_unused)
    );

    // Seconds only advance while truly running; commands and pause take priority.
    assign sec_en = scan_tick && (state_q == RUN) && !pause && !start && !clr;

    tick_prescaler #(.LIMIT(TICKS_PER_SEC - 1)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .en_i   (sec_en),
        .clr_i  (start || clr),
        .tick_o (sec_tick),
        .wrap_o (sec_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            time_left_q    <= '0;
            running_q      <= 1'b0;
            expired_q      <= 1'b0;
            expire_pulse_q <= 1'b0;
        end else begin
            expire_pulse_q <= 1'b0;
            if (clr) begin
                state_q     <= IDLE;
                time_left_q <= '0;
                running_q   <= 1'b0;
                expired_q   <= 1'b0;
            end else if (start) begin
                time_left_q <= round_len;
                if (round_len == '0) begin
                    state_q        <= EXPIRED;
                    running_q      <= 1'b0;
                    expired_q      <= 1'b1;
                    expire_pulse_q <= 1'b1;
                end else begin
                    state_q   <= RUN;
                    running_q <= 1'b1;
                    expired_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (pause) begin
                            state_q   <= PAUSED;
                            running_q <= 1'b0;
                        end else if (sec_wrap && time_left_q != '0) begin
                            time_left_q <= time_left_q - TW'(1);
                            if (time_left_q == TW'(1)) begin
                                state_q        <= EXPIRED;
                                running_q      <= 1'b0;
                                expired_q      <= 1'b1;
                                expire_pulse_q <= 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (!pause) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign time_left    = time_left_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign expire_pulse = expire_pulse_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Randomized bench for round_timer_ctrl against a cycle-level behavioural model.
module tb_round_timer_ctrl;

    localparam int D  = 3;
    localparam int T  = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, pause = 1'b0, clr = 1'b0;
    logic [TW-1:0] round_len = '0;
    logic          scan_tick, sec_tick, running, expired, expire_pulse;
    logic [TW-1:0] time_left;

    int checks = 0;
    int errors = 0;

    round_timer_ctrl #(.DIV_LIMIT(D), .TICKS_PER_SEC(T), .TW(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pause        (pause),
        .clr          (clr),
        .round_len    (round_len),
        .scan_tick    (scan_tick),
        .sec_tick     (sec_tick),
        .time_left    (time_left),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse)
    );

    always #5 clk = ~clk;

    // Reference: cycles since reset give the scan phase; scan ticks counted
    // within the current second give the seconds; a few flags give the mode.
    int            m_cyc, m_tk;
    logic          m_scan, m_sec, m_run, m_pau, m_exp, m_pulse;
    logic [TW-1:0] m_tl;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cyc <= 0; m_tk <= 0; m_tl <= '0;
            m_scan <= 0; m_sec <= 0; m_run <= 0; m_pau <= 0; m_exp <= 0; m_pulse <= 0;
        end else begin
            m_cyc   <= m_cyc + 1;
            m_scan  <= ((m_cyc + 1) % (D + 1)) == 0;
            m_sec   <= 0;
            m_pulse <= 0;
            if (clr) begin
                m_run <= 0; m_pau <= 0; m_exp <= 0; m_tl <= '0; m_tk <= 0;
            end else if (start) begin
                m_tk <= 0; m_tl <= round_len; m_pau <= 0;
                if (round_len == '0) begin
                    m_run <= 0; m_exp <= 1; m_pulse <= 1;
                end else begin
                    m_run <= 1; m_exp <= 0;
                end
            end else if (m_run) begin
                if (pause) begin
                    m_run <= 0; m_pau <= 1;
                end else if (m_scan) begin
                    if (m_tk == T - 1) begin
                        m_tk <= 0; m_sec <= 1; m_tl <= m_tl - 8'd1;
                        if (m_tl == 8'd1) begin
                            m_run <= 0; m_exp <= 1; m_pulse <= 1;
                        end
                    end else begin
                        m_tk <= m_tk + 1;
                    end
                end
            end else if (m_pau && !pause) begin
                m_pau <= 0; m_run <= 1;
            end
        end
    end

    wire [12:0] obs = {scan_tick, sec_tick, running, expired, expire_pulse, time_left};
    wire [12:0] mdl = {m_scan, m_sec, m_run, m_exp, m_pulse, m_tl};

    task automatic test_reset();
        int nscan = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL reset_state: got %h want 0", obs); end
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL idle: got %h want %h", obs, mdl); end
            if (scan_tick) nscan++;
        end
        checks++;
        if (nscan != 10) begin errors++; $display("FAIL idle_scan_count: got %0d want 10", nscan); end
    endtask

    task automatic test_countdown();
        int npulse = 0;
        round_len = 8'd3; start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL countdown: got %h want %h", obs, mdl); end
            if (i == 0) begin
                checks++;
                if (!running || time_left !== 8'd3) begin
                    errors++; $display("FAIL start_latency: got run=%b tl=%0d want run=1 tl=3", running, time_left);
                end
            end
            if (expire_pulse) npulse++;
            start = 1'b0;
        end
        checks++;
        if (npulse != 1 || !expired || running || time_left !== 8'd0) begin
            errors++;
            $display("FAIL countdown_end: got pulses=%0d exp=%b run=%b tl=%0d want 1 1 0 0", npulse, expired, running, time_left);
        end
    endtask

    task automatic test_pause();
        logic [TW-1:0] frozen;
        int nsec = 0;
        round_len = 8'd5; start = 1'b1;
        repeat ($urandom_range(20, 30)) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL pre_pause: got %h want %h", obs, mdl); end
            start = 1'b0;
        end
        frozen = time_left;
        pause = 1'b1;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL paused: got %h want %h", obs, mdl); end
            if (sec_tick) nsec++;
        end
        checks++;
        if (time_left !== frozen || nsec != 0) begin
            errors++; $display("FAIL pause_hold: got tl=%0d sec=%0d want tl=%0d sec=0", time_left, nsec, frozen);
        end
        pause = 1'b0;
        repeat (120) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL resumed: got %h want %h", obs, mdl); end
        end
        checks++;
        if (!expired) begin errors++; $display("FAIL pause_expire: got exp=%b want 1", expired); end
    endtask

    task automatic test_zero_len();
        round_len = 8'd0; start = 1'b1; clr = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (!expired || !expire_pulse || running || time_left !== 8'd0) begin
            errors++; $display("FAIL zero_len: got exp=%b pulse=%b run=%b tl=%0d want 1 1 0 0", expired, expire_pulse, running, time_left);
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL zero_len_hold: got %h want %h", obs, mdl); end
        end
    endtask

    task automatic test_clr_start();
        logic [TW-1:0] rl;
        int waited = 0;
        round_len = 8'($urandom_range(2, 6)); start = 1'b1;
        repeat ($urandom_range(5, 30)) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL clr_pre: got %h want %h", obs, mdl); end
            start = 1'b0;
        end
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        checks++;
        if (running || expired || time_left !== 8'd0) begin
            errors++; $display("FAIL clr_start: got run=%b exp=%b tl=%0d want 0 0 0", running, expired, time_left);
        end
        round_len = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(m_run && m_scan && m_tk == T - 1 && m_tl == 8'd1) && waited < 100) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL final_wait: got %h want %h", obs, mdl); end
            waited++;
        end
        checks++;
        if (waited >= 100) begin errors++; $display("FAIL final_timeout: got %0d cycles want <100", waited); end
        rl = 8'($urandom_range(2, 9));
        round_len = rl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (time_left !== rl || expire_pulse || !running || sec_tick) begin
            errors++; $display("FAIL start_vs_expiry: got tl=%0d pulse=%b run=%b sec=%b want %0d 0 1 0", time_left, expire_pulse, running, sec_tick, rl);
        end
    endtask

    task automatic test_random();
        start = 0; clr = 0; pause = 0;
        repeat (1500) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL random: got %h want %h", obs, mdl); end
            start     = ($urandom % 20) == 0;
            clr       = ($urandom % 50) == 0;
            round_len = 8'($urandom % 4);
            if (($urandom % 15) == 0) pause = ~pause;
        end
        start = 0; clr = 0; pause = 0;
    endtask

    task automatic test_rst_mid();
        int first = -1;
        round_len = 8'd4; start = 1'b1;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 13'd0) begin errors++; $display("FAIL async_reset: got %h want 0", obs); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== mdl) begin errors++; $display("FAIL post_reset: got %h want %h", obs, mdl); end
            if (scan_tick && first < 0) first = i;
        end
        checks++;
        if (first != D + 1) begin errors++; $display("FAIL scan_rephase: got %0d want %0d", first, D + 1); end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_zero_len();
        test_clr_start();
        test_random();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
